// File: rtl/rst_sequencer.sv
// rst_sequencer
// Staged reset release for the board subsystems (stage 0 = CPU, stage 1 =
// video/tilemap, stage 2 = sound). Also hosts the game watchdog. A watchdog
// expiry or a software request re-runs the same staged release sequence.
//
// Optional feature: define RST_SEQ_WDOG_EN to build the watchdog counter and
// expiry logic. Without it wdog_kick is ignored, wdog_fired stays 0 and
// rst_cause never reports a watchdog reboot; soft_rst_req still works.
module rst_sequencer #(
   parameter int unsigned STAGES      = 3,
   parameter int unsigned HOLD_CYCLES = 16,
   parameter int unsigned WDOG_LIMIT  = 4096
) (
   input  logic              clk,
   input  logic              reset_s,
   input  logic              wdog_kick,
   input  logic              soft_rst_req,
   output logic [STAGES-1:0] rst_out,
   output logic              ready,
   output logic              wdog_fired,
   output logic [1:0]        rst_cause
);

   localparam int unsigned HCNT_W = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
   localparam int unsigned IDX_W  = (STAGES > 1) ? $clog2(STAGES) : 1;
   localparam logic [HCNT_W-1:0] HCNT_LAST = HCNT_W'(HOLD_CYCLES - 1);
   localparam logic [IDX_W-1:0]  IDX_LAST  = IDX_W'(STAGES - 1);

   localparam logic [1:0] CAUSE_POR  = 2'b00;
   localparam logic [1:0] CAUSE_SOFT = 2'b01;
   localparam logic [1:0] CAUSE_WDOG = 2'b10;

   typedef enum logic [1:0] {
      ST_HOLD    = 2'd0,
      ST_RELEASE = 2'd1,
      ST_RUN     = 2'd2,
      ST_REBOOT  = 2'd3
   } state_t;

   state_t             state_q, state_d;
   logic [HCNT_W-1:0]  hcnt_q, hcnt_d;
   logic [IDX_W-1:0]   idx_q, idx_d;
   logic [STAGES-1:0]  rst_out_q, rst_out_d;
   logic               ready_q, ready_d;
   logic               fired_q, fired_d;
   logic [1:0]         cause_q, cause_d;
   logic               wdog_expire_s;

`ifdef RST_SEQ_WDOG_EN
   localparam int unsigned WCNT_W = $clog2(WDOG_LIMIT + 1);
   localparam logic [WCNT_W-1:0] WCNT_LAST = WCNT_W'(WDOG_LIMIT - 1);
   localparam logic [WCNT_W-1:0] WCNT_MAX  = WCNT_W'(WDOG_LIMIT);

   logic [WCNT_W-1:0] wcnt_q, wcnt_d;

   // Watchdog: count RUN cycles since the last kick and flag the terminal cycle
   always_comb begin
      wcnt_d        = '0;
      wdog_expire_s = 1'b0;
      if (state_q == ST_RUN) begin
         if (wdog_kick) begin
            // a kick in the terminal cycle still rescues the system
            wcnt_d = '0;
         end else if (wcnt_q == WCNT_LAST) begin
            wcnt_d        = wcnt_q + 1'b1;
            wdog_expire_s = 1'b1;
         end else if (wcnt_q >= WCNT_MAX) begin
            wcnt_d = WCNT_MAX;
         end else begin
            wcnt_d = wcnt_q + 1'b1;
         end
      end else begin
         wcnt_d = '0;
      end
   end

   // Watchdog counter register; held at zero whenever the next state is not RUN
   always_ff @(posedge clk) begin
      if (reset_s) begin
         wcnt_q <= '0;
      end else if (state_d != ST_RUN) begin
         wcnt_q <= '0;
      end else begin
         wcnt_q <= wcnt_d;
      end
   end
`else
   logic unused_kick_s;

   // Watchdog absent: the kick input has no effect and expiry never happens
   always_comb begin
      unused_kick_s = wdog_kick;
      wdog_expire_s = 1'b0;
   end
`endif

   // Sequencer next-state: staged release, RUN supervision and reboot hold
   always_comb begin
      state_d   = state_q;
      hcnt_d    = hcnt_q;
      idx_d     = idx_q;
      rst_out_d = rst_out_q;
      ready_d   = ready_q;
      fired_d   = fired_q;
      cause_d   = cause_q;
      case (state_q)
         ST_HOLD, ST_RELEASE: begin
            if (hcnt_q == HCNT_LAST) begin
               // idx is 0 in HOLD, so the first terminal count frees the CPU
               hcnt_d           = '0;
               rst_out_d[idx_q] = 1'b0;
               if (idx_q == IDX_LAST) begin
                  state_d = ST_RUN;
                  ready_d = 1'b1;
                  idx_d   = idx_q;
               end else begin
                  state_d = ST_RELEASE;
                  idx_d   = idx_q + 1'b1;
               end
            end else begin
               hcnt_d = hcnt_q + 1'b1;
            end
         end
         ST_RUN: begin
            // watchdog expiry outranks a simultaneous software request
            if (wdog_expire_s) begin
               state_d = ST_REBOOT;
               cause_d = CAUSE_WDOG;
               fired_d = 1'b1;
            end else if (soft_rst_req) begin
               state_d = ST_REBOOT;
               cause_d = CAUSE_SOFT;
            end else begin
               state_d = ST_RUN;
            end
            if (state_d == ST_REBOOT) begin
               rst_out_d = '1;
               ready_d   = 1'b0;
               hcnt_d    = '0;
               idx_d     = '0;
            end else begin
               rst_out_d = rst_out_q;
            end
         end
         ST_REBOOT: begin
            if (hcnt_q == HCNT_LAST) begin
               state_d = ST_HOLD;
               hcnt_d  = '0;
               idx_d   = '0;
            end else begin
               hcnt_d = hcnt_q + 1'b1;
            end
         end
         default: begin
            state_d   = ST_HOLD;
            hcnt_d    = '0;
            idx_d     = '0;
            rst_out_d = '1;
            ready_d   = 1'b0;
         end
      endcase
   end

   // Sequencer state and output registers; reset_s overrides every input
   always_ff @(posedge clk) begin
      if (reset_s) begin
         state_q   <= ST_HOLD;
         hcnt_q    <= '0;
         idx_q     <= '0;
         rst_out_q <= '1;
         ready_q   <= 1'b0;
         fired_q   <= 1'b0;
         cause_q   <= CAUSE_POR;
      end else begin
         state_q   <= state_d;
         hcnt_q    <= hcnt_d;
         idx_q     <= idx_d;
         rst_out_q <= rst_out_d;
         ready_q   <= ready_d;
         fired_q   <= fired_d;
         cause_q   <= cause_d;
      end
   end

   assign rst_out    = rst_out_q;
   assign ready      = ready_q;
   assign wdog_fired = fired_q;
   assign rst_cause  = cause_q;

endmodule

// File: tb/tb_rst_sequencer.sv
// tb_rst_sequencer: scoreboard bench for rst_sequencer (STAGES=3,
// HOLD_CYCLES=4, WDOG_LIMIT=32). The driver updates a time-based reference
// model and queues the expected outputs; a monitor compares every cycle.
// Define RST_SEQ_WDOG_EN for both bench and design to cover the watchdog.
module tb_rst_sequencer;

   localparam int S = 3;
   localparam int H = 4;
   localparam int L = 32;
`ifdef RST_SEQ_WDOG_EN
   localparam bit WD_EN = 1'b1;
`else
   localparam bit WD_EN = 1'b0;
`endif

   localparam int M_SEQ = 0;
   localparam int M_RUN = 1;
   localparam int M_RB  = 2;

   logic         clk          = 1'b0;
   logic         reset_s      = 1'b1;
   logic         wdog_kick    = 1'b0;
   logic         soft_rst_req = 1'b0;
   logic [S-1:0] rst_out;
   logic         ready;
   logic         wdog_fired;
   logic [1:0]   rst_cause;

   rst_sequencer #(.STAGES(S), .HOLD_CYCLES(H), .WDOG_LIMIT(L)) dut (
      .clk          (clk),
      .reset_s      (reset_s),
      .wdog_kick    (wdog_kick),
      .soft_rst_req (soft_rst_req),
      .rst_out      (rst_out),
      .ready        (ready),
      .wdog_fired   (wdog_fired),
      .rst_cause    (rst_cause)
   );

   always #5 clk = ~clk;

   typedef struct packed {
      logic [S-1:0] rst;
      logic         rdy;
      logic         fired;
      logic [1:0]   cause;
   } exp_t;

   exp_t sb_q[$];
   int   n_checks = 0;
   int   n_fail   = 0;
   int   cyc_no   = 0;

   // reference model: elapsed-time view of the sequence
   int         m_mode  = M_SEQ;
   int         m_t     = 0;   // edges since start of the release sequence
   int         m_wd    = 0;   // RUN cycles since entry or last kick
   int         m_r     = 0;   // edges spent in reboot hold
   logic [1:0] m_cause = 2'b00;
   logic       m_fired = 1'b0;

   function automatic void model_step(input bit r, input bit k, input bit s);
      bit expire;
      if (r) begin
         m_mode = M_SEQ; m_t = 0; m_wd = 0; m_r = 0;
         m_cause = 2'b00; m_fired = 1'b0;
      end else if (m_mode == M_SEQ) begin
         m_t = m_t + 1;
         if (m_t == S * H) begin
            m_mode = M_RUN;
            m_wd   = 0;
         end
      end else if (m_mode == M_RUN) begin
         expire = WD_EN && !k && (m_wd == L - 1);
         if (expire) begin
            m_cause = 2'b10; m_fired = 1'b1; m_mode = M_RB; m_r = 0;
         end else if (s) begin
            m_cause = 2'b01; m_mode = M_RB; m_r = 0;
         end else if (k) begin
            m_wd = 0;
         end else begin
            m_wd = m_wd + 1;
         end
      end else begin
         m_r = m_r + 1;
         if (m_r == H) begin
            m_mode = M_SEQ;
            m_t    = 0;
         end
      end
   endfunction

   function automatic exp_t model_out();
      exp_t e;
      e.cause = m_cause;
      e.fired = m_fired;
      if (m_mode == M_SEQ) begin
         for (int k = 0; k < S; k++) e.rst[k] = (m_t >= (k + 1) * H) ? 1'b0 : 1'b1;
         e.rdy = 1'b0;
      end else if (m_mode == M_RUN) begin
         e.rst = '0;
         e.rdy = 1'b1;
      end else begin
         e.rst = '1;
         e.rdy = 1'b0;
      end
      return e;
   endfunction

   // drive one cycle of inputs and queue the expected result of the next edge
   task automatic cyc(input logic r, input logic k, input logic s);
      @(negedge clk);
      reset_s      = r;
      wdog_kick    = k;
      soft_rst_req = s;
      model_step(r, k, s);
      sb_q.push_back(model_out());
   endtask

   task automatic after_edge();
      @(posedge clk);
      #2;
   endtask

   task automatic dchk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endtask

   // monitor: compare DUT outputs with the queued expectation after each edge
   initial begin
      exp_t e;
      forever begin
         @(posedge clk);
         #1;
         if (sb_q.size() > 0) begin
            e = sb_q.pop_front();
            cyc_no++;
            n_checks++;
            if ({rst_out, ready, wdog_fired, rst_cause} !== e) begin
               n_fail++;
               $display("FAIL cycle %0d: rst_out=%b ready=%b fired=%b cause=%b, expected rst_out=%b ready=%b fired=%b cause=%b",
                        cyc_no, rst_out, ready, wdog_fired, rst_cause, e.rst, e.rdy, e.fired, e.cause);
            end
         end
      end
   end

   // stimulus
   initial begin
      // power-up: reset held, then staged release with periodic kicks
      for (int i = 0; i < 5; i++) cyc(1'b1, 1'b0, 1'b0);
      after_edge();
      dchk("reset_rst_out", rst_out, 3'b111);
      dchk("reset_ready", ready, 1'b0);
      for (int e = 1; e <= 12; e++) begin
         cyc(1'b0, (e % 10 == 0), 1'b0);
         after_edge();
         if (e == 3)  dchk("pu_e3_rst", rst_out, 3'b111);
         if (e == 4)  dchk("pu_e4_rst", rst_out, 3'b110);
         if (e == 8)  dchk("pu_e8_rst", rst_out, 3'b100);
         if (e == 11) dchk("pu_e11_ready", ready, 1'b0);
         if (e == 12) begin
            dchk("pu_e12_rst", rst_out, 3'b000);
            dchk("pu_e12_ready", ready, 1'b1);
            dchk("pu_cause", rst_cause, 2'b00);
         end
      end
      for (int i = 0; i < 30; i++) cyc(1'b0, (i % 10 == 9), 1'b0);

      // software reset in RUN, then a request during RELEASE that must be ignored
      cyc(1'b0, 1'b0, 1'b1);
      after_edge();
      dchk("soft_rst_out", rst_out, 3'b111);
      dchk("soft_ready", ready, 1'b0);
      dchk("soft_cause", rst_cause, 2'b01);
      dchk("soft_fired", wdog_fired, 1'b0);
      for (int i = 1; i <= 16; i++) begin
         cyc(1'b0, 1'b0, (i == 10));
         after_edge();
         if (i == 7)  dchk("soft_e7_rst", rst_out, 3'b111);
         if (i == 8)  dchk("soft_e8_rst", rst_out, 3'b110);
         if (i == 16) dchk("soft_ignored_ready", ready, 1'b1);
      end

      // reset_s at edge 6 of a release sequence
      cyc(1'b0, 1'b0, 1'b1);
      for (int i = 1; i <= 9; i++) cyc(1'b0, 1'b0, 1'b0);
      cyc(1'b1, 1'b0, 1'b0);
      after_edge();
      dchk("midrst_rst_out", rst_out, 3'b111);
      dchk("midrst_cause", rst_cause, 2'b00);
      for (int e = 1; e <= 12; e++) begin
         cyc(1'b0, 1'b0, 1'b0);
         after_edge();
         if (e == 4)  dchk("midrst_e4_rst", rst_out, 3'b110);
         if (e == 12) dchk("midrst_e12_ready", ready, 1'b1);
      end

`ifdef RST_SEQ_WDOG_EN
      // watchdog expiry 32 cycles after RUN entry, then the full re-release
      for (int i = 1; i <= 32; i++) begin
         cyc(1'b0, 1'b0, 1'b0);
         after_edge();
         if (i == 31) dchk("wd_e31_ready", ready, 1'b1);
         if (i == 32) begin
            dchk("wd_rst_out", rst_out, 3'b111);
            dchk("wd_ready", ready, 1'b0);
            dchk("wd_fired", wdog_fired, 1'b1);
            dchk("wd_cause", rst_cause, 2'b10);
         end
      end
      for (int i = 1; i <= 16; i++) begin
         cyc(1'b0, 1'b0, 1'b0);
         after_edge();
         if (i == 7)  dchk("wd_rb7_rst", rst_out, 3'b111);
         if (i == 8)  dchk("wd_rb8_rst", rst_out, 3'b110);
         if (i == 15) dchk("wd_rb15_ready", ready, 1'b0);
         if (i == 16) dchk("wd_rb16_ready", ready, 1'b1);
      end
      // kick exactly when the counter sits at its terminal value
      for (int i = 1; i <= 40; i++) begin
         cyc(1'b0, (i == 32), 1'b0);
         after_edge();
         if (i == 32) dchk("kick_boundary_ready", ready, 1'b1);
      end
      for (int j = 0; j < 1000; j++) cyc(1'b0, (j % 31 == 0), 1'b0);
      after_edge();
      dchk("kick31_ready", ready, 1'b1);
      // software reset keeps the sticky watchdog flag
      cyc(1'b0, 1'b0, 1'b1);
      after_edge();
      dchk("soft2_cause", rst_cause, 2'b01);
      dchk("soft2_fired", wdog_fired, 1'b1);
      for (int i = 1; i <= 16; i++) cyc(1'b0, 1'b0, 1'b0);
      // software request in the expiry cycle: watchdog cause wins
      for (int i = 1; i <= 32; i++) begin
         cyc(1'b0, 1'b0, (i == 32));
         after_edge();
         if (i == 32) dchk("simul_cause", rst_cause, 2'b10);
      end
      for (int i = 1; i <= 16; i++) cyc(1'b0, 1'b0, 1'b0);
`else
      // no watchdog: long idle RUN must not reboot
      for (int i = 0; i < 200; i++) cyc(1'b0, 1'b0, 1'b0);
      after_edge();
      dchk("nowd_ready", ready, 1'b1);
      dchk("nowd_fired", wdog_fired, 1'b0);
      dchk("nowd_cause", rst_cause, 2'b00);
`endif

      // random traffic against the model
      for (int i = 0; i < 800; i++) begin
         cyc(($urandom_range(0, 399) == 0), ($urandom_range(0, 19) == 0),
             ($urandom_range(0, 149) == 0));
      end

      @(posedge clk);
      #3;
      dchk("scoreboard_drained", sb_q.size(), 0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
